amdc_gpio_mux_axi_core: RTL and testbench

AMDC_GPIO_MUX_AXI_CORE -- requirements
Module: amdc_gpio_mux_axi_core

---
 rtl/amdc_gpio_mux_axi_core.sv | 203 ++++++++++++++++++++
 tb/tb_amdc_gpio_mux_axi_core.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amdc_gpio_mux_axi_core.sv
// amdc_gpio_mux_axi_core
//   GPIO crossbar with an AXI4-Lite register slave. Each physical port p selects
//   one internal device (SEL[p]); changing a selection inserts GUARD_CYCLES idle
//   cycles on that port (break-before-make) before the new device is connected.
// Ports:
//   ACLK, ARESET          clock, asynchronous active-high reset
//   S_AXI_*               AXI4-Lite slave (8-bit address, 32-bit data)
//   dev_out / dev_in      device-side pins, device d at slice d
//   gpio_out / gpio_in    port-side pins, port p at slice p
// Optional build macro:
//   GPIO_MUX_INPUT_SYNC_EN  adds a 2-flop synchronizer on gpio_in (gpio_in->dev_in = 3 cycles)
module amdc_gpio_mux_axi_core #(
  parameter int NUM_PORTS    = 4,
  parameter int NUM_DEVICES  = 8,
  parameter int PIN_W        = 4,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [7:0]                   S_AXI_AWADDR,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [31:0]                  S_AXI_WDATA,
  input  logic [3:0]                   S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  input  logic [7:0]                   S_AXI_ARADDR,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  output logic [31:0]                  S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,
  input  logic [NUM_DEVICES*PIN_W-1:0] dev_out,
  output logic [NUM_DEVICES*PIN_W-1:0] dev_in,
  output logic [NUM_PORTS*PIN_W-1:0]   gpio_out,
  input  logic [NUM_PORTS*PIN_W-1:0]   gpio_in
);

  localparam int          PW          = NUM_PORTS * PIN_W;
  localparam int          DW          = NUM_DEVICES * PIN_W;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [7:0]  ADDR_STATUS = 8'h40;
  localparam logic [7:0]  ADDR_INFO   = 8'h44;
  localparam logic [7:0]  GUARD_LOAD  = 8'(GUARD_CYCLES);
  localparam logic [31:0] INFO_VAL    = {8'(GUARD_CYCLES), 8'(NUM_DEVICES), 8'(NUM_PORTS), 8'(PIN_W)};

  logic [7:0]           sel_q   [NUM_PORTS];
  logic [7:0]           sel_d   [NUM_PORTS];
  logic [7:0]           guard_q [NUM_PORTS];
  logic [7:0]           guard_d [NUM_PORTS];
  logic                 awready_q, awready_d;
  logic                 bvalid_q, bvalid_d;
  logic [1:0]           bresp_q, bresp_d;
  logic                 arready_q, arready_d;
  logic                 rvalid_q, rvalid_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [1:0]           rresp_q, rresp_d;
  logic [PW-1:0]        gpio_out_q, gpio_out_d;
  logic [DW-1:0]        dev_in_q, dev_in_d;
  logic [NUM_PORTS-1:0] status, wr_hit, rd_hit;
  logic                 wr_fire, wr_ok, rd_fire;
  logic [PW-1:0]        gpio_src;
  logic                 unused_ok;

  assign unused_ok = ^{S_AXI_WDATA[31:8], S_AXI_WSTRB[3:1]};

`ifdef GPIO_MUX_INPUT_SYNC_EN
  logic [PW-1:0] sync1_q, sync2_q;
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
    end
  end
  assign gpio_src = sync2_q;
`else
  assign gpio_src = gpio_in;
`endif

  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    status = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      wr_hit[p] = (S_AXI_AWADDR == 8'(4 * p));
      rd_hit[p] = (S_AXI_ARADDR == 8'(4 * p));
      status[p] = (guard_q[p] != 8'd0);
    end
    // READY pulses are one cycle wide; the handshake edge is the one where READY is high.
    wr_fire = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    rd_fire = arready_q & S_AXI_ARVALID;
    wr_ok   = (|wr_hit) & S_AXI_WSTRB[0] & (S_AXI_WDATA[7:0] <= 8'(NUM_DEVICES));

    awready_d = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
    arready_d = S_AXI_ARVALID & ~rvalid_q & ~arready_q;

    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (wr_fire) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    // A selection change restarts the guard; rewriting the current value is a no-op.
    for (int p = 0; p < NUM_PORTS; p++) begin
      sel_d[p]   = sel_q[p];
      guard_d[p] = (guard_q[p] != 8'd0) ? guard_q[p] - 8'd1 : 8'd0;
      if (wr_fire && wr_ok && wr_hit[p] && (S_AXI_WDATA[7:0] != sel_q[p])) begin
        sel_d[p]   = S_AXI_WDATA[7:0];
        guard_d[p] = GUARD_LOAD;
      end
    end

    // Read data is taken from pre-edge state, so a same-cycle write is not visible.
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_OKAY;
      if (|rd_hit) begin
        for (int p = 0; p < NUM_PORTS; p++)
          if (rd_hit[p]) rdata_d = {24'd0, sel_q[p]};
      end else if (S_AXI_ARADDR == ADDR_STATUS) begin
        rdata_d = 32'(status);
      end else if (S_AXI_ARADDR == ADDR_INFO) begin
        rdata_d = INFO_VAL;
      end else begin
        rresp_d = RESP_SLVERR;
      end
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end

    gpio_out_d = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      for (int d = 0; d < NUM_DEVICES; d++)
        if (guard_q[p] == 8'd0 && sel_q[p] == 8'(d + 1))
          gpio_out_d[p*PIN_W +: PIN_W] = dev_out[d*PIN_W +: PIN_W];

    // Scan ports high to low so the lowest-index matching port wins.
    dev_in_d = '0;
    for (int d = 0; d < NUM_DEVICES; d++)
      for (int p = NUM_PORTS - 1; p >= 0; p--)
        if (guard_q[p] == 8'd0 && sel_q[p] == 8'(d + 1))
          dev_in_d[d*PIN_W +: PIN_W] = gpio_src[p*PIN_W +: PIN_W];
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        sel_q[p]   <= 8'd0;
        guard_q[p] <= 8'd0;
      end
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
      gpio_out_q <= '0;
      dev_in_q   <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        sel_q[p]   <= sel_d[p];
        guard_q[p] <= guard_d[p];
      end
      awready_q  <= awready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      gpio_out_q <= gpio_out_d;
      dev_in_q   <= dev_in_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign gpio_out      = gpio_out_q;
  assign dev_in        = dev_in_q;

endmodule

// File: tb/tb_amdc_gpio_mux_axi_core.sv
module tb_amdc_gpio_mux_axi_core;

  localparam int NP  = 4;
  localparam int ND  = 8;
  localparam int PW  = 4;
  localparam int GC  = 2;
  localparam int GWD = NP * PW;
  localparam int DWD = ND * PW;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic            ACLK = 1'b0;
  logic            ARESET = 1'b1;
  logic [7:0]      awaddr = '0;
  logic            awvalid = 1'b0;
  logic            S_AXI_AWREADY, S_AXI_WREADY;
  logic [31:0]     wdata = '0;
  logic [3:0]      wstrb = '0;
  logic            wvalid = 1'b0;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            bready = 1'b0;
  logic [7:0]      araddr = '0;
  logic            arvalid = 1'b0;
  logic            S_AXI_ARREADY;
  logic [31:0]     S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RVALID;
  logic            rready = 1'b0;
  logic [DWD-1:0]  dev_out = '0;
  logic [DWD-1:0]  dev_in;
  logic [GWD-1:0]  gpio_out;
  logic [GWD-1:0]  gpio_in = '0;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] sel_m [NP];

  amdc_gpio_mux_axi_core #(.NUM_PORTS(NP), .NUM_DEVICES(ND), .PIN_W(PW), .GUARD_CYCLES(GC)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(rready),
    .dev_out(dev_out), .dev_in(dev_in), .gpio_out(gpio_out), .gpio_in(gpio_in)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int c_commit);
    int n;
    @(negedge ACLK);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge ACLK);
    n = 0;
    while (!S_AXI_AWREADY && n < 16) begin @(negedge ACLK); n++; end
    if (!S_AXI_AWREADY) chk("awready_timeout", {31'd0, S_AXI_AWREADY}, 32'd1);
    @(posedge ACLK); #1;
    c_commit = cyc;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!S_AXI_BVALID && n < 16) begin @(negedge ACLK); n++; end
    if (!S_AXI_BVALID) chk("bvalid_timeout", {31'd0, S_AXI_BVALID}, 32'd1);
    resp = S_AXI_BRESP;
    @(posedge ACLK); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int c_hs);
    int n;
    @(negedge ACLK);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    @(negedge ACLK);
    n = 0;
    while (!S_AXI_ARREADY && n < 16) begin @(negedge ACLK); n++; end
    if (!S_AXI_ARREADY) chk("arready_timeout", {31'd0, S_AXI_ARREADY}, 32'd1);
    @(posedge ACLK); #1;
    c_hs = cyc;
    arvalid = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < 16) begin @(negedge ACLK); n++; end
    if (!S_AXI_RVALID) chk("rvalid_timeout", {31'd0, S_AXI_RVALID}, 32'd1);
    d = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    @(posedge ACLK); #1;
    rready = 1'b0;
  endtask

  // Settled-state expectations (all guards expired) from the selection table.
  function automatic logic [GWD-1:0] m_gpio_out();
    logic [GWD-1:0] r;
    r = '0;
    for (int p = 0; p < NP; p++)
      if (sel_m[p] != 8'd0)
        r[p*PW +: PW] = PW'(dev_out >> (PW * (int'(sel_m[p]) - 1)));
    return r;
  endfunction

  function automatic logic [DWD-1:0] m_dev_in();
    logic [DWD-1:0] r;
    r = '0;
    for (int d = 0; d < ND; d++) begin
      int hit;
      hit = -1;
      for (int p = 0; p < NP; p++)
        if (hit < 0 && int'(sel_m[p]) == d + 1) hit = p;
      if (hit >= 0) r[d*PW +: PW] = gpio_in[hit*PW +: PW];
    end
    return r;
  endfunction

  function automatic logic [31:0] m_reg(input logic [7:0] a);
    if (a < 8'(4 * NP) && a[1:0] == 2'b00) return {24'd0, sel_m[a[7:2]]};
    if (a == 8'h44) return {8'(GC), 8'(ND), 8'(NP), 8'(PW)};
    return 32'd0;
  endfunction

  initial begin
    logic [31:0] rd, r32;
    logic [1:0]  rsp, rsp2;
    int          c_w, c_r, p, v;
    int          mon_c [10];
    logic [3:0]  mon_v [10];
    logic [3:0]  s;
    logic        seen, ok;
    logic [7:0]  a;

    for (int i = 0; i < NP; i++) sel_m[i] = 8'd0;

    // Reset state
    repeat (3) @(negedge ACLK);
    chk("rst_outputs", {16'd0, gpio_out}, 32'd0);
    chk("rst_dev_in", dev_in, 32'd0);
    chk("rst_hs", {25'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_BRESP[0], S_AXI_RRESP[0]}, 32'd0);
    ARESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      axi_read(8'(4 * i), rd, rsp, c_r);
      chk("rst_sel_data", rd, 32'd0);
      chk("rst_sel_resp", {30'd0, rsp}, {30'd0, OKAY});
    end
    axi_read(8'h40, rd, rsp, c_r);
    chk("rst_status", rd, 32'd0);
    chk("rst_status_resp", {30'd0, rsp}, {30'd0, OKAY});
    axi_read(8'h44, rd, rsp, c_r);
    chk("info", rd, 32'h0208_0404);
    axi_read(8'h50, rd, rsp, c_r);
    chk("unmapped_rd_data", rd, 32'd0);
    chk("unmapped_rd_resp", {30'd0, rsp}, {30'd0, SLVERR});

    // Break-before-make on port 1 switching to device 2
    dev_out = 32'h0000_0A00;
    fork
      axi_write(8'h04, 32'd3, 4'hF, rsp, c_w);
      begin @(negedge ACLK); axi_read(8'h40, rd, rsp2, c_r); end
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge ACLK);
          mon_c[i] = cyc;
          mon_v[i] = gpio_out[7:4];
        end
      end
    join
    sel_m[1] = 8'd3;
    chk("sel1_bresp", {30'd0, rsp}, {30'd0, OKAY});
    chk("status_in_guard", rd, ((c_r - 1 >= c_w) && (c_r - 1 < c_w + GC)) ? 32'h2 : 32'h0);
    chk("status_read_lands_in_guard", c_r, c_w + 1);
    for (int i = 0; i < 10; i++)
      chk("guard_gpio_out1", {28'd0, mon_v[i]}, (mon_c[i] >= c_w + GC + 1) ? 32'hA : 32'h0);
    axi_read(8'h40, rd, rsp, c_r);
    chk("status_after_guard", rd, 32'h0);
    axi_read(8'h04, rd, rsp, c_r);
    chk("sel1_readback", rd, 32'd3);

    // Same-cycle read and write to SEL[3] returns the old value
    fork
      axi_write(8'h0C, 32'd5, 4'hF, rsp, c_w);
      axi_read(8'h0C, rd, rsp2, c_r);
    join
    chk("rw_same_cycle", c_r, c_w);
    chk("rw_pre_write_value", rd, {24'd0, sel_m[3]});
    sel_m[3] = 8'd5;
    axi_read(8'h0C, rd, rsp, c_r);
    chk("sel3_readback", rd, 32'd5);

    // Error writes
    axi_write(8'h00, 32'd9, 4'hF, rsp, c_w);
    chk("sel_too_big_resp", {30'd0, rsp}, {30'd0, SLVERR});
    axi_read(8'h00, rd, rsp, c_r);
    chk("sel_too_big_unchanged", rd, {24'd0, sel_m[0]});
    axi_write(8'h48, 32'd1, 4'hF, rsp, c_w);
    chk("unmapped_wr_resp", {30'd0, rsp}, {30'd0, SLVERR});
    axi_write(8'h40, 32'd1, 4'hF, rsp, c_w);
    chk("ro_wr_resp", {30'd0, rsp}, {30'd0, SLVERR});
    axi_write(8'h00, 32'd1, 4'hE, rsp, c_w);
    chk("strb0_wr_resp", {30'd0, rsp}, {30'd0, SLVERR});
    axi_read(8'h00, rd, rsp, c_r);
    chk("strb0_unchanged", rd, {24'd0, sel_m[0]});

    // AWVALID early, BREADY held low
    @(negedge ACLK);
    awaddr = 8'h08; wdata = 32'd4; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
    seen = 1'b0;
    repeat (5) begin @(negedge ACLK); if (S_AXI_AWREADY) seen = 1'b1; end
    chk("no_awready_without_w", {31'd0, seen}, 32'd0);
    wvalid = 1'b1;
    @(negedge ACLK);
    for (int n = 0; n < 16 && !S_AXI_AWREADY; n++) @(negedge ACLK);
    chk("awready_with_w", {31'd0, S_AXI_AWREADY}, 32'd1);
    @(posedge ACLK); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    sel_m[2] = 8'd4;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      chk("bvalid_held", {31'd0, S_AXI_BVALID}, 32'd1);
      chk("bresp_stable", {30'd0, S_AXI_BRESP}, {30'd0, OKAY});
    end
    bready = 1'b1;
    @(posedge ACLK); #1;
    bready = 1'b0;
    @(negedge ACLK);
    chk("bvalid_cleared", {31'd0, S_AXI_BVALID}, 32'd0);

    // Randomized selections against the settled-state model
    for (int it = 0; it < 30; it++) begin
      p = $urandom_range(NP - 1, 0);
      v = $urandom_range(ND + 2, 0);
      s = ($urandom_range(4, 0) == 0) ? 4'hE : 4'hF;
      ok = (v <= ND) && s[0];
      axi_write(8'(4 * p), 32'(v), s, rsp, c_w);
      chk("rand_bresp", {30'd0, rsp}, ok ? {30'd0, OKAY} : {30'd0, SLVERR});
      if (ok) sel_m[p] = 8'(v);
      repeat (GC + 2) @(negedge ACLK);
      r32 = $urandom; dev_out = DWD'(r32);
      r32 = $urandom; gpio_in = GWD'(r32);
      repeat (4) @(negedge ACLK);
      chk("rand_gpio_out", {16'd0, gpio_out}, {16'd0, m_gpio_out()});
      chk("rand_dev_in", dev_in, m_dev_in());
      axi_read(8'(4 * p), rd, rsp, c_r);
      chk("rand_sel_readback", rd, {24'd0, sel_m[p]});
      a = 8'(4 * $urandom_range(19, 0));
      axi_read(a, rd, rsp, c_r);
      chk("rand_reg_data", rd, m_reg(a));
      chk("rand_reg_resp", {30'd0, rsp}, (a < 8'(4 * NP) || a == 8'h40 || a == 8'h44) ? {30'd0, OKAY} : {30'd0, SLVERR});
    end

    // Lowest-index port wins when two ports share a device
    axi_write(8'h00, 32'd2, 4'hF, rsp, c_w);
    sel_m[0] = 8'd2;
    axi_write(8'h08, 32'd2, 4'hF, rsp, c_w);
    sel_m[2] = 8'd2;
    gpio_in = 16'hC935;
    dev_out = 32'h1234_5678;
    repeat (GC + 5) @(negedge ACLK);
    chk("shared_dev_in1", {28'd0, dev_in[7:4]}, 32'h5);
    chk("shared_dev_in_all", dev_in, m_dev_in());
    chk("shared_gpio_out", {16'd0, gpio_out}, {16'd0, m_gpio_out()});

    // Reset in the middle of a write
    @(negedge ACLK);
    awaddr = 8'h04; wdata = 32'd6; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge ACLK);
    for (int n = 0; n < 16 && !S_AXI_AWREADY; n++) @(negedge ACLK);
    chk("midrst_awready_before", {31'd0, S_AXI_AWREADY}, 32'd1);
    ARESET = 1'b1;
    #1;
    chk("midrst_hs", {25'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_BRESP[1], S_AXI_RRESP[1]}, 32'd0);
    chk("midrst_rdata", S_AXI_RDATA, 32'd0);
    chk("midrst_gpio_out", {16'd0, gpio_out}, 32'd0);
    chk("midrst_dev_in", dev_in, 32'd0);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < NP; i++) sel_m[i] = 8'd0;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(negedge ACLK); if (S_AXI_BVALID) seen = 1'b1; end
    chk("midrst_no_bvalid", {31'd0, seen}, 32'd0);
    bready = 1'b0;
    axi_read(8'h04, rd, rsp, c_r);
    chk("midrst_sel1_cleared", rd, 32'd0);
    chk("midrst_dev_in_after", dev_in, m_dev_in());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
